// File: rtl/prism_pkg.sv
// prism_pkg: shared defaults, sequencer state type and word-assembly helpers
// for the PRISM configuration chain loader.
package prism_pkg;

    localparam int PRISM_WIDTH      = 48;
    localparam int PRISM_DEPTH      = 8;
    localparam int PRISM_FIFO_DEPTH = 2;

    // Bits of a config word that come from the high bus write.
    localparam int PRISM_HI_WIDTH   = PRISM_WIDTH - 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        GUARD = 2'd2
    } prism_state_t;

    // High-half width for an arbitrary word width (low half is always 32 bits).
    function automatic int hiWidth(input int width);
        return width - 32;
    endfunction

endpackage

// File: rtl/prism_cfg_fifo.sv
// prism_cfg_fifo: small synchronous FIFO holding assembled config words ahead
// of the sequencer. A push into a full FIFO is taken only when a pop happens
// in the same cycle. flush empties it synchronously.
module prism_cfg_fifo
    import prism_pkg::*;
#(
    parameter int W = PRISM_WIDTH,
    parameter int D = PRISM_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PW = (D > 1) ? $clog2(D) : 1;
    localparam int CW = $clog2(D + 1);

    logic [W-1:0]  r_mem [D];
    logic [PW-1:0] r_rdPtr;
    logic [PW-1:0] r_wrPtr;
    logic [CW-1:0] r_count;
    logic          w_doPush;
    logic          w_doPop;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_doPop  = pop && !empty;
    assign w_doPush = push && (!full || w_doPop);

    // Storage write; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping, cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= nextPtr(r_wrPtr);
            end
            if (w_doPop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rdPtr];
    assign full  = (r_count == CW'(D));
    assign empty = (r_count == '0);

endmodule

// File: rtl/prism_config_sequencer.sv
// prism_config_sequencer: assembles 48-bit config words from two bus writes,
// buffers them, and shifts each one into the PRISM latch chain by pulsing
// one-hot latch enables from the last stage down to stage 0.
// Optional build macro PRISM_CFG_GUARD_EN inserts an all-off GUARD cycle
// between consecutive enables (2*DEPTH+1 cycles per word instead of DEPTH+1).
// WIDTH must be in the range 33..64.
module prism_config_sequencer
    import prism_pkg::*;
#(
    parameter int WIDTH      = PRISM_WIDTH,
    parameter int DEPTH      = PRISM_DEPTH,
    parameter int FIFO_DEPTH = PRISM_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_lo,
    input  logic                         wr_hi,
    input  logic [31:0]                  wdata,
    input  logic                         clear,
    output logic [WIDTH-1:0]             config_data,
    output logic [DEPTH-1:0]             latch_en,
    output logic                         busy,
    output logic                         fifo_full,
    output logic [$clog2(DEPTH+1)-1:0]   words_loaded,
    output logic                         chain_full,
    output logic                         overflow
);

    localparam int HI_W = hiWidth(WIDTH);
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WL   = $clog2(DEPTH + 1);

    prism_state_t     r_state;
    prism_state_t     w_nextState;
    logic [IW-1:0]    r_idx;
    logic [IW-1:0]    w_nextIdx;
    logic [DEPTH-1:0] r_latchEn;
    logic [DEPTH-1:0] w_nextLatchEn;
    logic [WIDTH-1:0] r_configData;
    logic [31:0]      r_loStage;
    logic [WL-1:0]    r_wordsLoaded;
    logic             r_overflow;
    logic             w_pop;
    logic             w_push;
    logic             w_wordDone;
    logic             w_fifoFull;
    logic             w_fifoEmpty;
    logic [WIDTH-1:0] w_assembled;
    logic [WIDTH-1:0] w_fifoHead;

    assign w_assembled = {wdata[HI_W-1:0], r_loStage};

    generate
        if (HI_W < 32) begin : g_unusedHi
            logic w_unusedHi;
            assign w_unusedHi = ^wdata[31:HI_W];
        end
    endgenerate

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign w_push = wr_hi && !clear && (!w_fifoFull || w_pop);

    prism_cfg_fifo #(
        .W (WIDTH),
        .D (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (clear),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_assembled),
        .dout  (w_fifoHead),
        .full  (w_fifoFull),
        .empty (w_fifoEmpty)
    );

    // Next-state, stage index and next latch enable; clear forces IDLE.
    always_comb begin
        w_nextState = r_state;
        w_nextIdx   = r_idx;
        w_pop       = 1'b0;
        w_wordDone  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifoEmpty) begin
                    w_pop       = 1'b1;
                    w_nextState = OPEN;
                    w_nextIdx   = IW'(DEPTH - 1);
                end
            end
            OPEN: begin
`ifdef PRISM_CFG_GUARD_EN
                w_nextState = GUARD;
`else
                if (r_idx == '0) begin
                    w_nextState = IDLE;
                    w_wordDone  = 1'b1;
                end else begin
                    w_nextIdx = r_idx - IW'(1);
                end
`endif
            end
`ifdef PRISM_CFG_GUARD_EN
            GUARD: begin
                if (r_idx == '0) begin
                    w_nextState = IDLE;
                    w_wordDone  = 1'b1;
                end else begin
                    w_nextState = OPEN;
                    w_nextIdx   = r_idx - IW'(1);
                end
            end
`endif
            default: w_nextState = IDLE;
        endcase
        if (clear) begin
            w_nextState = IDLE;
            w_pop       = 1'b0;
            w_wordDone  = 1'b0;
        end
        w_nextLatchEn = (w_nextState == OPEN) ? (DEPTH'(1) << w_nextIdx) : '0;
    end

    // State, index and registered latch enables.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_latchEn <= '0;
        end else begin
            r_state   <= w_nextState;
            r_idx     <= w_nextIdx;
            r_latchEn <= w_nextLatchEn;
        end
    end

    // Chain input word, loaded on pop and held across clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_configData <= '0;
        end else if (w_pop) begin
            r_configData <= w_fifoHead;
        end
    end

    // Low staging register; a same-cycle wr_hi has already used the old value.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_loStage <= '0;
        end else if (wr_lo) begin
            r_loStage <= wdata;
        end
    end

    // Saturating progress counter and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_wordsLoaded <= '0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_wordDone && (r_wordsLoaded != WL'(DEPTH))) begin
                r_wordsLoaded <= r_wordsLoaded + WL'(1);
            end
            if (wr_hi && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign config_data  = r_configData;
    assign latch_en     = r_latchEn;
    assign busy         = (r_state != IDLE) || !w_fifoEmpty;
    assign fifo_full    = w_fifoFull;
    assign words_loaded = r_wordsLoaded;
    assign chain_full   = (r_wordsLoaded == WL'(DEPTH));
    assign overflow     = r_overflow;

endmodule

// File: doc/prism_config_sequencer.md
# prism_config_sequencer

Sequences loading of the PRISM latch-based configuration chain (WIDTH-bit stages, DEPTH deep) from TinyQV bus writes. Assembles 48-bit config words from two bus writes and buffers them in a small FIFO. Shifts each word into the latch chain by pulsing one-hot latch enables from the last stage down to stage 0, so no two latches are ever transparent together. Sits between the peripheral register decode and the latch shift register, and reports progress and overflow back to software.

## Interface
- WIDTH, 48, config word / latch stage width (low 32 bits + high WIDTH-32 bits)
- DEPTH, 8, number of latch stages in the chain
- FIFO_DEPTH, 2, assembled words buffered ahead of the sequencer
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- wr_lo  input  1  strobe: capture wdata[31:0] into the low staging register
- wr_hi  input  1  strobe: assemble {wdata[WIDTH-33:0], lo_stage} and push it to the FIFO
- wdata  input  32  bus write data
- clear  input  1  synchronous flush/abort
- config_data  output  WIDTH  word driven to the chain input (stage 0), registered
- latch_en  output  DEPTH  one-hot-or-zero latch enables, registered
- busy  output  1  high when state != IDLE or FIFO not empty
- fifo_full  output  1  FIFO holds FIFO_DEPTH words
- words_loaded  output  $clog2(DEPTH+1)  words shifted since reset/clear, saturating at DEPTH
- chain_full  output  1  words_loaded == DEPTH
- overflow  output  1  sticky: a wr_hi was dropped because the FIFO was full

## Operation
- Reset: config_data=0, latch_en=0, busy=0, fifo_full=0, words_loaded=0, chain_full=0, overflow=0, lo_stage=0, FIFO empty, state IDLE.
- wr_lo loads lo_stage. lo_stage is not cleared by wr_hi, so repeated wr_hi reuses the last low half.
- wr_hi pushes the assembled word when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the word is dropped and overflow is set.
- wr_lo and wr_hi in the same cycle: wr_hi uses the old lo_stage; lo_stage then updates.
- States: IDLE, OPEN, GUARD.
  - IDLE with FIFO non-empty: pop the head into config_data, set idx=DEPTH-1, go to OPEN.
  - OPEN: latch_en = onehot(idx) for exactly one cycle.
    - idx>0: go to GUARD, then back to OPEN with idx-1.
    - idx==0: go to GUARD, then IDLE, and increment words_loaded (saturating).
  - GUARD: latch_en = 0.
- config_data holds constant from the pop until the next pop.
- Stage k captures stage k-1 (stage 0 captures config_data). After N ≤ DEPTH words, the most recent word is in stage 0.
- clear has priority over all other inputs. Next cycle:
  - state IDLE, latch_en=0, FIFO empty, lo_stage=0, words_loaded=0, overflow=0.
  - config_data is retained.
  - A wr_hi in the same cycle as clear is discarded and does not set overflow.
- Mid-operation clear or reset leaves the chain partially shifted. Software reloads all DEPTH words.

## Timing
- Pop at cycle T (IDLE). latch_en[k] is high in cycle T+1+2·(DEPTH-1-k).
  - With the defaults: latch_en[7] at T+1, latch_en[0] at T+15.
- GUARD at T+16, IDLE at T+17. words_loaded shows the increment at T+17.
- Back-to-back words: the next pop is at T+17, giving 2·DEPTH+1 cycles per word.
- Push to FIFO is visible to IDLE the next cycle. A word written into an empty idle block pops one cycle after wr_hi.
- busy rises the cycle after an accepted wr_hi. It falls in the IDLE cycle after the last word completes with the FIFO empty.

## Configuration
- PRISM_CFG_GUARD_EN defined: GUARD cycles are inserted as above, at 2·DEPTH+1 cycles per word.
- Not defined: no GUARD state.
  - OPEN steps idx down every cycle. latch_en[k] is high at T+1+(DEPTH-1-k).
  - After idx==0, go directly to IDLE; the increment is visible at T+DEPTH+1.
  - Throughput is DEPTH+1 cycles per word.
  - Still strictly one-hot; adjacent enables never overlap in a cycle.

## Structure
- Shared package prism_pkg holds:
  - the WIDTH/DEPTH defaults
  - the state enum {IDLE, OPEN, GUARD}
  - the word-assembly width constant (WIDTH-32)
- One sub-module, prism_cfg_fifo: a synchronous FIFO parameterized on width/depth, with push, pop, full, empty and flush.
- The sequencer FSM, idx counter, staging register and status logic live in prism_config_sequencer.

## Test plan
- Write lo=0x89ABCDEF then hi=0x0123 (guard on) -> config_data=0x012389ABCDEF.
  - latch_en goes 0x80, 0x00, 0x40, …, 0x01 on alternate cycles.
  - words_loaded=1 at T+17; busy then drops.
- Load 8 distinct words back-to-back -> stage0..7 hold words 8..1; chain_full=1.
  - A 9th word leaves words_loaded=8 (saturated).
- Issue 4 wr_hi with 1-cycle spacing while sequencing -> first two accepted (fifo_full=1), third dropped and overflow=1, fourth accepted only if it coincides with a pop.
- Assert clear at latch_en=0x10 mid-word -> next cycle latch_en=0, busy=0, words_loaded=0, overflow=0, FIFO empty.
- Assert wr_hi and clear in the same cycle -> no push, busy stays 0.
- PRISM_CFG_GUARD_EN undefined -> latch_en steps 0x80..0x01 on consecutive cycles; next pop at T+9.
- Assert rst_n low at T+5 of a sequence -> all outputs at their reset values next cycle.
